// File: rtl/fetch_pkg_ysyx.sv
// Shared types and defaults for the ysyx fetch front end.
package fetch_pkg_ysyx;

    localparam int unsigned     XLEN_DEF     = 32;
    localparam logic [31:0]     RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0]     NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
    } fetch_entry_t;

endpackage

// File: rtl/ibuf_fifo_ysyx.sv
// Circular instruction buffer holding {pc, inst}; head is combinational off the read pointer.
module ibuf_fifo_ysyx
    import fetch_pkg_ysyx::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    // Flush wins over both ends; a pop on an empty buffer is a no-op.
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;
    assign do_push = push_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_ysyx.sv
// Decoupled instruction fetch: owned PC, pipelined imem requests, redirect flush, instruction buffer.
// Optional performance counters are compiled in with the FETCH_PERF_EN macro.
module fetch_unit_ysyx
    import fetch_pkg_ysyx::*;
#(
    parameter int unsigned      XLEN            = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC        = RESET_PC_DEF,
    parameter int unsigned      IBUF_DEPTH      = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst_data,
    output logic [XLEN-1:0]     inst_pc,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                halt,
`ifdef FETCH_PERF_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt,
    output logic [31:0]         perf_stall_cnt,
`endif
    output logic                busy
);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic [PW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic            req_fire, rsp_live, push;
    int unsigned     reserved;
    fetch_entry_t    push_entry, head;

    // Slots already promised to live in-flight requests count against the buffer.
    assign reserved = 32'(count) + 32'(pending_q) - 32'(drop_q);

    assign imem_req_valid = rst_n & ~halt & ~redirect_valid
                          & (32'(pending_q) < MAX_OUTSTANDING) & (reserved < IBUF_DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_live       = imem_rsp_valid & (pending_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        push       = 1'b0;
        pending_d  = pending_q + PW'(req_fire) - PW'(rsp_live);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = pending_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_live) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - PW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
        end
    end

    assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

    ibuf_fifo_ysyx #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (inst_valid & inst_ready),
        .flush_i (redirect_valid),
        .wdata_i (push_entry),
        .head_o  (head),
        .count_o (count)
    );

    assign inst_valid = (count != '0);
    assign inst_pc    = head.pc;
    assign inst_data  = inst_valid ? head.inst : NOP;
    assign busy       = (pending_q != '0) | (count != '0);

    // A response with nothing outstanding breaks the in-order protocol.
    assert property (@(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (pending_q != '0));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (req_fire && perf_fetch_q != '1)       perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect_valid && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
            if (!halt && !imem_req_valid && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit_ysyx.sv
// Scoreboard bench for fetch_unit_ysyx: a latency-configurable memory model feeds the DUT,
// issued fetches are queued as expectations and matched against entries decode pops.
module tb_fetch_unit_ysyx;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt, busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

    fetch_unit_ysyx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } fl_t;

    int total, bad, cyc, lat;
    ent_t obs[$], exp_at_pop[$], want[$];
    fl_t  infl[$];
    logic [31:0] iss[$];
    int          iss_cyc[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Record what fires at the coming edge, advance one cycle, then drive this cycle's response.
    task automatic step();
        ent_t e;
        fl_t  f;
        #1;
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                iss.push_back(imem_req_addr);
                iss_cyc.push_back(cyc);
                f.addr = imem_req_addr;
                f.due  = cyc + lat;
                infl.push_back(f);
                e.pc   = imem_req_addr;
                e.inst = mem_f(imem_req_addr);
                e.cyc  = cyc;
                want.push_back(e);
            end
            if (redirect_valid) begin
                want.delete();
            end else if (inst_valid && inst_ready) begin
                e.pc   = inst_pc;
                e.inst = inst_data;
                e.cyc  = cyc;
                obs.push_back(e);
                if (want.size() > 0) begin
                    exp_at_pop.push_back(want.pop_front());
                end else begin
                    e.pc   = 'x;
                    e.inst = 'x;
                    exp_at_pop.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (infl.size() > 0 && infl[0].due <= cyc) begin
            f = infl.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_f(f.addr);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        lat            = 1;
        repeat (2) @(negedge clk);
        obs.delete();
        exp_at_pop.delete();
        want.delete();
        infl.delete();
        iss.delete();
        iss_cyc.delete();
        cyc   = 0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drain(output bit ok);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (!busy && infl.size() == 0) break;
            step();
        end
        ok = !busy && (infl.size() == 0);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid);
        end
        total++;
        if (inst_valid !== 1'b0) begin
            bad++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (imem_req_addr !== 32'h8000_0000) begin
            bad++; $display("FAIL reset_addr got=%h want=80000000", imem_req_addr);
        end
    endtask

    task automatic test_stream();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (8) step();
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stream_drain got=busy want=idle"); end
        total++;
        if (iss.size() < 3) begin
            bad++; $display("FAIL stream_issue_cnt got=%0d want>=3", iss.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (iss[i] !== 32'h8000_0000 + 32'(4 * i)) begin
                    bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, iss[i],
                                    32'h8000_0000 + 32'(4 * i));
                end
            end
            total++;
            if (iss_cyc[2] - iss_cyc[0] != 2) begin
                bad++; $display("FAIL stream_b2b got=%0d want=2", iss_cyc[2] - iss_cyc[0]);
            end
        end
        total++;
        if (obs.size() < 3 || obs[0].cyc != 2) begin
            bad++; $display("FAIL stream_latency got=%0d want=2", obs.size() > 0 ? obs[0].cyc : -1);
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            total++;
            if (obs[i].pc !== 32'h8000_0000 + 32'(4 * i) || obs[i].inst !== mem_f(obs[i].pc)) begin
                bad++; $display("FAIL stream_pop[%0d] got=%h/%h want=%h", i, obs[i].pc,
                                obs[i].inst, 32'h8000_0000 + 32'(4 * i));
            end
        end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].pc !== exp_at_pop[i].pc || obs[i].inst !== exp_at_pop[i].inst) begin
                bad++; $display("FAIL stream_sb[%0d] got=%h/%h want=%h/%h", i, obs[i].pc,
                                obs[i].inst, exp_at_pop[i].pc, exp_at_pop[i].inst);
            end
        end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (10) step();
        total++;
        if (iss.size() != 4) begin
            bad++; $display("FAIL full_issue_cnt got=%0d want=4", iss.size());
        end
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL full_req_valid got=%b want=0", imem_req_valid);
        end
        inst_ready = 1'b1;
        repeat (6) step();
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_drain got=busy want=idle"); end
        total++;
        if (iss.size() < 5 || iss[4] !== 32'h8000_0010) begin
            bad++; $display("FAIL full_resume got=%h want=80000010", iss.size() > 4 ? iss[4] : 0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs.size() <= i || obs[i].pc !== 32'h8000_0000 + 32'(4 * i)) begin
                bad++; $display("FAIL full_order[%0d] got=%h want=%h", i,
                                obs.size() > i ? obs[i].pc : 0, 32'h8000_0000 + 32'(4 * i));
            end
        end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].pc !== exp_at_pop[i].pc || obs[i].inst !== exp_at_pop[i].inst) begin
                bad++; $display("FAIL full_sb[%0d] got=%h/%h want=%h/%h", i, obs[i].pc,
                                obs[i].inst, exp_at_pop[i].pc, exp_at_pop[i].inst);
            end
        end
    endtask

    task automatic test_redirect();
        bit ok;
        int stale;
        do_reset();
        lat            = 3;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();
        step();
        total++;
        if (iss.size() != 2 || imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL redir_inflight got=%0d/%b want=2/0", iss.size(), imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0) begin
            bad++; $display("FAIL redir_flush got=%b want=0", inst_valid);
        end
        repeat (8) step();
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL redir_drain got=busy want=idle"); end
        total++;
        if (iss.size() < 3 || iss[2] !== 32'h8000_0100) begin
            bad++; $display("FAIL redir_next_addr got=%h want=80000100", iss.size() > 2 ? iss[2] : 0);
        end
        total++;
        if (obs.size() < 1 || obs[0].pc !== 32'h8000_0100) begin
            bad++; $display("FAIL redir_first_pc got=%h want=80000100", obs.size() > 0 ? obs[0].pc : 0);
        end
        stale = 0;
        foreach (obs[i]) if (obs[i].pc < 32'h8000_0100) stale++;
        total++;
        if (stale != 0) begin bad++; $display("FAIL redir_stale got=%0d want=0", stale); end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].pc !== exp_at_pop[i].pc || obs[i].inst !== exp_at_pop[i].inst) begin
                bad++; $display("FAIL redir_sb[%0d] got=%h/%h want=%h/%h", i, obs[i].pc,
                                obs[i].inst, exp_at_pop[i].pc, exp_at_pop[i].inst);
            end
        end
`ifdef FETCH_PERF_EN
        total++;
        if (perf_flush_cnt !== 32'd1) begin
            bad++; $display("FAIL perf_flush got=%0d want=1", perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_same_cycle();
        bit ok;
        int stale;
        do_reset();
        lat            = 1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL same_empty got=%b/%b want=0/0", inst_valid, busy);
        end
        repeat (6) step();
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL same_drain got=busy want=idle"); end
        total++;
        if (obs.size() < 1 || obs[0].pc !== 32'h8000_0200) begin
            bad++; $display("FAIL same_first_pc got=%h want=80000200", obs.size() > 0 ? obs[0].pc : 0);
        end
        stale = 0;
        foreach (obs[i]) if (obs[i].pc < 32'h8000_0200) stale++;
        total++;
        if (stale != 0) begin bad++; $display("FAIL same_stale got=%0d want=0", stale); end
        for (int i = 0; i < obs.size(); i++) begin
            total++;
            if (obs[i].pc !== exp_at_pop[i].pc || obs[i].inst !== exp_at_pop[i].inst) begin
                bad++; $display("FAIL same_sb[%0d] got=%h/%h want=%h/%h", i, obs[i].pc,
                                obs[i].inst, exp_at_pop[i].pc, exp_at_pop[i].inst);
            end
        end
    endtask

    task automatic test_halt();
        bit ok;
        do_reset();
        lat            = 2;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        step();
        halt = 1'b1;
        repeat (4) step();
        total++;
        if (iss.size() != 1 || imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL halt_blocked got=%0d/%b want=1/0", iss.size(), imem_req_valid);
        end
        total++;
        if (busy !== 1'b1 || inst_valid !== 1'b1) begin
            bad++; $display("FAIL halt_buffered got=%b/%b want=1/1", busy, inst_valid);
        end
        total++;
        if (inst_pc !== 32'h8000_0000 || inst_data !== mem_f(32'h8000_0000)) begin
            bad++; $display("FAIL halt_head got=%h/%h want=80000000/%h", inst_pc, inst_data,
                            mem_f(32'h8000_0000));
        end
        inst_ready = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL halt_idle got=%b/%b want=0/0", busy, inst_valid);
        end
        halt = 1'b0;
        step();
        total++;
        if (iss.size() != 2 || iss[1] !== 32'h8000_0004) begin
            bad++; $display("FAIL halt_resume got=%h want=80000004", iss.size() > 1 ? iss[1] : 0);
        end
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL halt_drain got=busy want=idle"); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        step();
        step();
        drain(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wrap_drain got=busy want=idle"); end
        total++;
        if (iss.size() < 2 || iss[0] !== 32'hFFFF_FFFC || iss[1] !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_addr got=%h,%h want=fffffffc,00000000",
                            iss.size() > 0 ? iss[0] : 0, iss.size() > 1 ? iss[1] : 1);
        end
        total++;
        if (obs.size() < 2 || obs[0].pc !== 32'hFFFF_FFFC || obs[1].pc !== 32'h0000_0000
            || obs[1].inst !== mem_f(32'h0)) begin
            bad++; $display("FAIL wrap_pc got=%0d entries want=fffffffc,00000000", obs.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_same_cycle();
        test_halt();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
